slave_decoder: RTL

SLAVE_DECODER -- requirements
Module: slave_decoder

---
 rtl/slave_decoder.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/slave_decoder.sv
// Single-master address decoder: routes one request at a time to one of four slaves chosen by m_addr[31:30].
// Optional access timeout is compiled in with `define SLV_TIMEOUT_EN.
module slave_decoder #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m_req,
    input  logic        m_we,
    input  logic [31:0] m_addr,
    input  logic [31:0] m_wdata,
    output logic        m_ack,
    output logic        m_err,
    output logic        busy,
    output logic [1:0]  s_sel,
    output logic [3:0]  s_cs,
    output logic        s_we,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    input  logic [3:0]  s_ack,
    output logic [1:0]  dbg_state
);

    // Handshake: the master holds m_req until it sees the one-cycle m_ack pulse;
    // a slave ends its access by raising its own s_ack bit while its s_cs bit is high.

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be within 2..255");
    end

    state_t state;
    state_t state_next;
    logic   load;
    logic   ack_sel;

    assign ack_sel = s_ack[s_sel];

`ifdef SLV_TIMEOUT_EN
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] wait_cnt;
    logic       err_flag;
    logic       err_set;
    logic       err_clr;
    logic       cnt_inc;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        load       = 1'b0;
`ifdef SLV_TIMEOUT_EN
        err_set    = 1'b0;
        err_clr    = 1'b0;
        cnt_inc    = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (m_req) begin
                    load       = 1'b1;
                    state_next = ACCESS;
                end
            end
            ACCESS: begin
                // The selected ack wins over a timeout that expires in the same cycle.
                if (ack_sel) begin
                    state_next = DONE;
`ifdef SLV_TIMEOUT_EN
                    err_clr    = 1'b1;
                end else if (wait_cnt == TIMEOUT_LAST) begin
                    err_set    = 1'b1;
                    state_next = DONE;
                end else begin
                    cnt_inc    = 1'b1;
`endif
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Slave-side request fields are captured once and held through DONE so the
    // read-data mux stays valid while m_ack is high.
    always_ff @(posedge clk) begin
        if (reset) begin
            s_sel   <= 2'd0;
            s_we    <= 1'b0;
            s_addr  <= 32'd0;
            s_wdata <= 32'd0;
        end else if (load) begin
            s_sel   <= m_addr[31:30];
            s_we    <= m_we;
            s_addr  <= m_addr;
            s_wdata <= m_wdata;
        end
    end

`ifdef SLV_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt <= 8'd0;
            err_flag <= 1'b0;
        end else begin
            if (load) begin
                wait_cnt <= 8'd0;
            end else if (cnt_inc) begin
                wait_cnt <= wait_cnt + 8'd1;
            end

            if (load || err_clr) begin
                err_flag <= 1'b0;
            end else if (err_set) begin
                err_flag <= 1'b1;
            end
        end
    end

    assign m_err = (state == DONE) && err_flag;
`else
    assign m_err = 1'b0;
`endif

    assign s_cs      = (state == ACCESS) ? (4'b0001 << s_sel) : 4'b0000;
    assign m_ack     = (state == DONE);
    assign busy      = (state != IDLE);
    assign dbg_state = state;

endmodule
